// File: rtl/demux_stream_n_way.sv
// Registered valid/ready 1-to-N stream demultiplexer with one holding slot per
// output channel, broadcast mode, and discard accounting for out-of-range selects.
module demux_stream_n_way #(
  parameter int WIDTH = 16,
  parameter int WAYS  = 4,
  localparam int SEL_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             in_bcast,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data [WAYS],
  output logic [WAYS-1:0]  out_valid,
  input  logic [WAYS-1:0]  out_ready,
  output logic             err_pulse,
  output logic [7:0]       err_count
);

  localparam logic [SEL_W:0] WAYS_L = (SEL_W+1)'(WAYS);

  logic [WIDTH-1:0] r_data [WAYS];
  logic [WAYS-1:0]  r_valid;
  logic             r_err_pulse;
  logic [7:0]       r_err_count;

  logic [WAYS-1:0]  w_free;
  logic [WAYS-1:0]  w_sel_hit;
  logic [WAYS-1:0]  w_load;
  logic             w_in_range;
  logic             w_sel_free;
  logic             w_ready;
  logic             w_accept;
  logic             w_discard;

  // A slot can take a new word when it is empty or its word leaves this cycle.
  always_comb begin
    w_free     = ~r_valid | out_ready;
    w_in_range = ({1'b0, in_sel} < WAYS_L);
    w_sel_hit  = '0;
    w_sel_free = 1'b0;
    for (int j = 0; j < WAYS; j++) begin
      w_sel_hit[j] = (in_sel == SEL_W'(j));
      if (w_sel_hit[j] && w_free[j]) w_sel_free = 1'b1;
    end

    if (in_bcast)        w_ready = &w_free;
    else if (w_in_range) w_ready = w_sel_free;
    else                 w_ready = 1'b1;

    w_accept  = in_valid && w_ready;
    w_discard = w_accept && !in_bcast && !w_in_range;

    w_load = '0;
    if (w_accept) begin
      if (in_bcast)        w_load = '1;
      else if (w_in_range) w_load = w_sel_hit;
    end
  end

  // Load has priority over drain so a channel sustains one word per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= '0;
      r_err_pulse <= 1'b0;
      r_err_count <= 8'h00;
      for (int j = 0; j < WAYS; j++) r_data[j] <= '0;
    end else begin
      for (int j = 0; j < WAYS; j++) begin
        if (w_load[j]) begin
          r_valid[j] <= 1'b1;
          r_data[j]  <= in_data;
        end else if (r_valid[j] && out_ready[j]) begin
          r_valid[j] <= 1'b0;
          r_data[j]  <= '0;
        end
      end
      r_err_pulse <= w_discard;
      if (w_discard && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'h01;
    end
  end

  assign in_ready  = w_ready;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;

endmodule
